// File: rtl/bus_arb4.sv
// Four-requester round-robin arbiter with burst locking and a registered output beat.
// A locked owner that stays idle for LOCK_TIMEOUT cycles loses the lock and err_timeout pulses.
module bus_arb4 #(
  parameter int WIDTH        = 64,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req_valid,
  input  logic [3:0]       req_last,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  output logic             out_last,
  output logic             err_timeout
);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  // Handshake: a beat moves from requester i when req_valid[i] && req_ready[i]; the output
  // beat is consumed when out_valid && out_ready, and the slot refills in that same cycle.
  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;
  logic             out_last_q, out_last_d;
  logic             err_q, err_d;

  logic             slot_free;
  logic             found;
  logic             xfer;
  logic [1:0]       sel;
  logic [3:0]       ready;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    sel       = ptr_q;
    found     = 1'b0;
    // Descending scan so the candidate closest to ptr is the one left standing.
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[ptr_q + 2'(k)]) begin
        sel   = ptr_q + 2'(k);
        found = 1'b1;
      end
    end
    if (state_q == S_LOCKED) begin
      sel   = owner_q;
      found = 1'b1;
    end
    ready = '0;
    if (reset_n && found && slot_free) ready[sel] = 1'b1;
    xfer = |(ready & req_valid);
    case (sel)
      2'd0:    sel_data = req_data0;
      2'd1:    sel_data = req_data1;
      2'd2:    sel_data = req_data2;
      default: sel_data = req_data3;
    endcase

    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = sel;
      out_last_d  = req_last[sel];
      cnt_d       = '0;
      if (req_last[sel]) begin
        state_d = S_IDLE;
        ptr_d   = sel + 2'd1;
      end else if (state_q == S_IDLE) begin
        state_d = S_LOCKED;
        owner_d = sel;
      end
    end else begin
      if (slot_free) out_valid_d = 1'b0;
      if (state_q == S_LOCKED) begin
        if (req_valid[owner_q]) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          // Final idle cycle: drop the lock without inventing a closing beat.
          state_d = S_IDLE;
          ptr_d   = owner_q + 2'd1;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 2'd0;
      owner_q     <= 2'd0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign req_ready   = ready;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_src     = out_src_q;
  assign out_last    = out_last_q;
  assign err_timeout = err_q;
endmodule
